decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode.sv | 217 +++++++++++++++++++++
 tb/tb_decode.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode -- MIPS-subset instruction decode stage with register file and ID/EX
// pipeline register.
//
// Supported instructions: add (R-type funct 0x20), sub (R-type funct 0x22),
// addi (0x08), lw (0x23), sw (0x2B). Any other opcode/funct is consumed,
// raises a one-cycle ilegal pulse and loads a bubble into the ID/EX register.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   instruccion[31:0]       incoming instruction word
//   instruccion_valida      incoming word present
//   instruccion_lista       stage accepts the word this cycle
//   wb_escribe/registro/dato  writeback port into the register file
//   ex_listo                execute stage accepts the current bundle
//   valido                  ID/EX bundle valid
//   registro_1/registro_2   rs/rt operands
//   sign_extend             sign-extended immediate
//   sel                     ALU B source (0 = registro_2, 1 = sign_extend)
//   op                      ALU operation (0 = add, 1 = sub)
//   reg_destino             destination register
//   escribe_reg/lee_mem/escribe_mem  control bits
//   ilegal                  one-cycle illegal-instruction pulse
//
// Configuration macro: DECODE_BYPASS_EN -- when defined, a register read in
// the same cycle as a writeback to the same (non-zero) register returns the
// writeback data instead of the old contents. Port list is identical.
// -----------------------------------------------------------------------------
module decode (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruccion,
    input  logic        instruccion_valida,
    output logic        instruccion_lista,
    input  logic        wb_escribe,
    input  logic [4:0]  wb_registro,
    input  logic [31:0] wb_dato,
    input  logic        ex_listo,
    output logic        valido,
    output logic [31:0] registro_1,
    output logic [31:0] registro_2,
    output logic [31:0] sign_extend,
    output logic        sel,
    output logic        op,
    output logic [4:0]  reg_destino,
    output logic        escribe_reg,
    output logic        lee_mem,
    output logic        escribe_mem,
    output logic        ilegal
);

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] FUN_ADD   = 6'h20;
    localparam logic [5:0] FUN_SUB   = 6'h22;

    typedef enum logic {NORMAL, BURBUJA} estado_t;
    estado_t estado;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign opcode = instruccion[31:26];
    assign rs     = instruccion[25:21];
    assign rt     = instruccion[20:16];
    assign rd     = instruccion[15:11];
    assign imm    = instruccion[15:0];
    assign funct  = instruccion[5:0];

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    logic [31:0] rf [32];

    // NOTE: the register file is cleared by the asynchronous reset, which
    // forces it into flops rather than a RAM macro; that is intentional since
    // the pipeline relies on every register reading 0 after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_escribe && (wb_registro != 5'd0)) begin
            rf[wb_registro] <= wb_dato;
        end
    end

    logic [31:0] rs_dato, rt_dato;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first so no latch can be inferred.
    always_comb begin
        rs_dato = (rs == 5'd0) ? 32'd0 : rf[rs];
        rt_dato = (rt == 5'd0) ? 32'd0 : rf[rt];
`ifdef DECODE_BYPASS_EN
        if (wb_escribe && (wb_registro != 5'd0) && (wb_registro == rs)) rs_dato = wb_dato;
        if (wb_escribe && (wb_registro != 5'd0) && (wb_registro == rt)) rt_dato = wb_dato;
`endif
    end

    // -------------------------------------------------------------------------
    // Instruction decode
    // -------------------------------------------------------------------------
    logic       legal, usa_rt;
    logic       d_sel, d_op, d_er, d_lm, d_em;
    logic [4:0] d_dest;

    always_comb begin
        legal  = 1'b0;
        usa_rt = 1'b0;
        d_sel  = 1'b0;
        d_op   = 1'b0;
        d_er   = 1'b0;
        d_lm   = 1'b0;
        d_em   = 1'b0;
        d_dest = 5'd0;
        unique case (opcode)
            OPC_RTYPE: begin
                usa_rt = 1'b1;
                if (funct == FUN_ADD || funct == FUN_SUB) begin
                    legal  = 1'b1;
                    d_op   = (funct == FUN_SUB);
                    d_dest = rd;
                    d_er   = 1'b1;
                end
            end
            OPC_ADDI, OPC_LW: begin
                legal  = 1'b1;
                d_sel  = 1'b1;
                d_dest = rt;
                d_er   = 1'b1;
                d_lm   = (opcode == OPC_LW);
            end
            OPC_SW: begin
                legal  = 1'b1;
                usa_rt = 1'b1;
                d_sel  = 1'b1;
                d_em   = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake and load-use hazard
    // -------------------------------------------------------------------------
    logic avanza, hazard, acepta;

    // The bundle moves on when execute takes it or when it holds nothing.
    assign avanza = ex_listo || !valido;

    // A load in ID/EX whose target is needed by the incoming word: hold the
    // word one cycle and insert a bubble so the load data can be forwarded.
    assign hazard = instruccion_valida && valido && lee_mem && (reg_destino != 5'd0) &&
                    ((rs == reg_destino) || (usa_rt && (rt == reg_destino)));

    // Gating with reset keeps the stage from accepting anything while held.
    assign instruccion_lista = reset && avanza && !hazard;
    assign acepta            = instruccion_valida && instruccion_lista;

    // -------------------------------------------------------------------------
    // Hazard FSM and ID/EX register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= NORMAL;
            valido      <= 1'b0;
            registro_1  <= '0;
            registro_2  <= '0;
            sign_extend <= '0;
            sel         <= 1'b0;
            op          <= 1'b0;
            reg_destino <= '0;
            escribe_reg <= 1'b0;
            lee_mem     <= 1'b0;
            escribe_mem <= 1'b0;
            ilegal      <= 1'b0;
        end else if (avanza) begin
            unique case (estado)
                NORMAL:  if (hazard) estado <= BURBUJA;
                BURBUJA: estado <= NORMAL;
                default: estado <= NORMAL;
            endcase

            // An illegal word always leaves a bubble, so the pulse clears on
            // the following cycle, which is guaranteed to advance.
            ilegal <= acepta && !legal;

            if (acepta && legal) begin
                valido      <= 1'b1;
                registro_1  <= rs_dato;
                registro_2  <= rt_dato;
                sign_extend <= {{16{imm[15]}}, imm};
                sel         <= d_sel;
                op          <= d_op;
                reg_destino <= d_dest;
                escribe_reg <= d_er;
                lee_mem     <= d_lm;
                escribe_mem <= d_em;
            end else begin
                valido      <= 1'b0;
                registro_1  <= '0;
                registro_2  <= '0;
                sign_extend <= '0;
                sel         <= 1'b0;
                op          <= 1'b0;
                reg_destino <= '0;
                escribe_reg <= 1'b0;
                lee_mem     <= 1'b0;
                escribe_mem <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode -- scoreboard bench for the decode stage. Expected ID/EX bundles
// are built from a bench-side register model when a word is driven, queued,
// and compared when the stage loads them.
// -----------------------------------------------------------------------------
module tb_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruccion;
    logic        instruccion_valida;
    logic        instruccion_lista;
    logic        wb_escribe;
    logic [4:0]  wb_registro;
    logic [31:0] wb_dato;
    logic        ex_listo;
    logic        valido;
    logic [31:0] registro_1, registro_2, sign_extend;
    logic        sel, op;
    logic [4:0]  reg_destino;
    logic        escribe_reg, lee_mem, escribe_mem, ilegal;

    decode dut (
        .clock              (clock),
        .reset              (reset),
        .instruccion        (instruccion),
        .instruccion_valida (instruccion_valida),
        .instruccion_lista  (instruccion_lista),
        .wb_escribe         (wb_escribe),
        .wb_registro        (wb_registro),
        .wb_dato            (wb_dato),
        .ex_listo           (ex_listo),
        .valido             (valido),
        .registro_1         (registro_1),
        .registro_2         (registro_2),
        .sign_extend        (sign_extend),
        .sel                (sel),
        .op                 (op),
        .reg_destino        (reg_destino),
        .escribe_reg        (escribe_reg),
        .lee_mem            (lee_mem),
        .escribe_mem        (escribe_mem),
        .ilegal             (ilegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        valido;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] se;
        logic        sel;
        logic        op;
        logic [4:0]  dest;
        logic        er;
        logic        lm;
        logic        em;
    } bundle_t;

    bundle_t     sb[$];
    logic [31:0] model [32];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic bundle_t observed();
        return {valido, registro_1, registro_2, sign_extend, sel, op,
                reg_destino, escribe_reg, lee_mem, escribe_mem};
    endfunction

    function automatic bundle_t mk(input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] se, input logic s, input logic o,
                                   input logic [4:0] d, input logic er,
                                   input logic lm, input logic em);
        return {1'b1, r1, r2, se, s, o, d, er, lm, em};
    endfunction

    function automatic logic [31:0] sx(input logic [31:0] w);
        return {{16{w[15]}}, w[15:0]};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_escribe  = 1'b1;
        wb_registro = a;
        wb_dato     = d;
        step();
        wb_escribe  = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    // Presents a word, waits (bounded) until it is accepted, queues its
    // expected bundle and lets the accepting edge pass.
    task automatic send(input logic [31:0] w, input bundle_t e);
        int n;
        instruccion        = w;
        instruccion_valida = 1'b1;
        #1;
        n = 0;
        while (!instruccion_lista && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (!instruccion_lista) begin
            miscompares++;
            $display("FAIL send_accept word=%h lista=%b after %0d cycles, need 1", w, instruccion_lista, n);
        end
        sb.push_back(e);
        step();
        instruccion_valida = 1'b0;
    endtask

    task automatic test_reset();
        bundle_t got;
        reset              = 1'b0;
        ex_listo           = 1'b1;
        wb_escribe         = 1'b0;
        wb_registro        = '0;
        wb_dato            = '0;
        instruccion        = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        instruccion_valida = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (3) @(posedge clock);
        #1;
        got = observed();
        vectors++;
        if (got !== '0 || instruccion_lista !== 1'b0 || ilegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h lista=%b ilegal=%b, need all 0", got, instruccion_lista, ilegal);
        end
        instruccion_valida = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if (instruccion_lista !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_lista got=%b need 1", instruccion_lista);
        end
        step();
        vectors++;
        if (valido !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_word_discarded valido=%b need 0", valido);
        end
    endtask

    task automatic test_add();
        bundle_t got, e;
        logic [31:0] w;
        wb_write(5'd1, 32'd2);
        wb_write(5'd2, 32'd2);
        w = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        send(w, mk(model[1], model[2], sx(w), 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0));
        got = observed();
        e   = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL add_bundle got=%h need %h", got, e);
        end
        step();
        vectors++;
        if (valido !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_bubble valido=%b need 0", valido);
        end
    endtask

    task automatic test_addi();
        bundle_t got, e;
        send(itype(6'h08, 5'd1, 5'd4, 16'hFFFC),
             mk(model[1], model[4], 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0));
        got = observed();
        e   = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL addi_bundle got=%h need %h", got, e);
        end
    endtask

    task automatic test_load_use();
        bundle_t got, e;
        logic [31:0] w;
        wb_write(5'd5, 32'h0000_0033);
        send(itype(6'h23, 5'd1, 5'd5, 16'h0004),
             mk(model[1], model[5], 32'd4, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0));
        got = observed();
        e   = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL lw_bundle got=%h need %h", got, e);
        end
        w = rtype(5'd5, 5'd2, 5'd6, 6'h22);
        instruccion        = w;
        instruccion_valida = 1'b1;
        #1;
        vectors++;
        if (instruccion_lista !== 1'b0) begin
            miscompares++;
            $display("FAIL hazard_lista got=%b need 0", instruccion_lista);
        end
        step();
        vectors++;
        if ({valido, instruccion_lista} !== 2'b01) begin
            miscompares++;
            $display("FAIL hazard_bubble valido,lista=%b%b need 01", valido, instruccion_lista);
        end
        sb.push_back(mk(model[5], model[2], sx(w), 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0));
        step();
        instruccion_valida = 1'b0;
        got = observed();
        e   = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL sub_after_bubble got=%h need %h", got, e);
        end
    endtask

    task automatic test_stall();
        bundle_t got, e1, e2;
        logic [31:0] w;
        w = rtype(5'd1, 5'd2, 5'd9, 6'h20);
        send(w, mk(model[1], model[2], sx(w), 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0));
        e1 = sb.pop_front();
        ex_listo           = 1'b0;
        instruccion        = itype(6'h08, 5'd2, 5'd10, 16'h0005);
        instruccion_valida = 1'b1;
        sb.push_back(mk(model[2], model[10], 32'd5, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0));
        #1;
        for (int i = 0; i < 4; i++) begin
            got = observed();
            vectors++;
            if (got !== e1 || instruccion_lista !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got=%h lista=%b need %h lista=0", i, got, instruccion_lista, e1);
            end
            if (i < 3) step();
        end
        ex_listo = 1'b1;
        #1;
        vectors++;
        if (instruccion_lista !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release_lista got=%b need 1", instruccion_lista);
        end
        step();
        instruccion_valida = 1'b0;
        got = observed();
        e2  = sb.pop_front();
        vectors++;
        if (got !== e2) begin
            miscompares++;
            $display("FAIL stall_advance got=%h need %h", got, e2);
        end
    endtask

    task automatic test_illegal();
        bundle_t got, e;
        logic [31:0] w;
        logic [31:0] bad [2];
        bad[0] = {6'h3F, 26'h0};
        bad[1] = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        for (int i = 0; i < 2; i++) begin
            instruccion        = bad[i];
            instruccion_valida = 1'b1;
            step();
            instruccion_valida = 1'b0;
            vectors++;
            if ({ilegal, valido} !== 2'b10) begin
                miscompares++;
                $display("FAIL illegal_pulse[%0d] ilegal,valido=%b%b need 10", i, ilegal, valido);
            end
            step();
            vectors++;
            if (ilegal !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_one_cycle[%0d] ilegal=%b need 0", i, ilegal);
            end
        end
        wb_write(5'd0, 32'hDEAD_BEEF);
        w = rtype(5'd0, 5'd0, 5'd11, 6'h20);
        send(w, mk(32'd0, 32'd0, sx(w), 1'b0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0));
        got = observed();
        e   = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL r0_reads_zero got=%h need %h", got, e);
        end
    endtask

    task automatic test_bypass();
        bundle_t got, e;
        logic [31:0] w, exp_r7;
        wb_write(5'd7, 32'h0000_0011);
`ifdef DECODE_BYPASS_EN
        exp_r7 = 32'h0000_00A5;
`else
        exp_r7 = model[7];
`endif
        w = rtype(5'd7, 5'd7, 5'd12, 6'h20);
        wb_escribe         = 1'b1;
        wb_registro        = 5'd7;
        wb_dato            = 32'h0000_00A5;
        instruccion        = w;
        instruccion_valida = 1'b1;
        sb.push_back(mk(exp_r7, exp_r7, sx(w), 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0));
        step();
        wb_escribe         = 1'b0;
        instruccion_valida = 1'b0;
        model[7]           = 32'h0000_00A5;
        got = observed();
        e   = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL same_cycle_wb got=%h need %h", got, e);
        end
    endtask

    task automatic test_reset_mid_stall();
        bundle_t got, e;
        logic [31:0] w;
        w = rtype(5'd1, 5'd2, 5'd13, 6'h20);
        send(w, mk(model[1], model[2], sx(w), 1'b0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0));
        got = observed();
        e   = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL pre_stall_bundle got=%h need %h", got, e);
        end
        ex_listo           = 1'b0;
        instruccion        = rtype(5'd2, 5'd1, 5'd14, 6'h22);
        instruccion_valida = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        got = observed();
        vectors++;
        if (got !== '0 || instruccion_lista !== 1'b0 || ilegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_stall got=%h lista=%b ilegal=%b, need all 0", got, instruccion_lista, ilegal);
        end
        instruccion_valida = 1'b0;
        ex_listo           = 1'b1;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        step();
        w = rtype(5'd1, 5'd2, 5'd15, 6'h20);
        send(w, mk(model[1], model[2], sx(w), 1'b0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0));
        got = observed();
        e   = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL regfile_cleared got=%h need %h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_load_use();
        test_stall();
        test_illegal();
        test_bypass();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
